// File: rtl/sub48_seq_pkg.sv
// Shared constants, FSM encoding and flag helper for the sliced 48-bit subtractor.
package sub48_seq_pkg;

  localparam int W      = 48;
  localparam int SLICE  = 16;
  localparam int NSLICE = W / SLICE;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow of A - B: operands differ in sign and the result sign flips away from A.
  function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/sub48_seq_adder16.sv
// 16-bit slice adder with carry in/out, reused once per slice by sub48_seq.
module adder16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_c0,
  output logic [15:0] o_s,
  output logic        o_c16
);

  logic [16:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {16'b0, i_c0};
  assign o_s    = w_full[15:0];
  assign o_c16  = w_full[16];

endmodule

// File: rtl/sub48_seq.sv
// Multi-cycle 48-bit subtractor D = A - B, one 16-bit slice per cycle as A + ~B + 1.
module sub48_seq
  import sub48_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:1]   A,
  input  logic [W:1]   B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:1]   D,
  output logic         bout,
  output logic         ovf
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [W:1]         r_a;
  logic [W:1]         r_bn;
  logic [W:1]         r_d;
  logic               r_bout;
  logic               r_ovf;
  logic               r_out_valid;
  logic               r_in_ready;

  logic [SLICE-1:0]   w_a_slice;
  logic [SLICE-1:0]   w_bn_slice;
  logic [SLICE-1:0]   w_sum;
  logic               w_cout;
  logic               w_last;

  assign w_a_slice  = r_a[SLICE*r_idx+1 +: SLICE];
  assign w_bn_slice = r_bn[SLICE*r_idx+1 +: SLICE];
  assign w_last     = (r_idx == IDX_W'(NSLICE - 1));

  adder16 u_slice (
    .i_a   (w_a_slice),
    .i_b   (w_bn_slice),
    .i_c0  (r_carry),
    .o_s   (w_sum),
    .o_c16 (w_cout)
  );

  // Operands carry no reset; they are only consumed after a fresh accept.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid) begin
      r_a  <= A;
      r_bn <= ~B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_carry    <= 1'b1;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_d[SLICE*r_idx+1 +: SLICE] <= w_sum;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            // Borrow is the complement of the final carry of A + ~B + 1.
            r_bout      <= ~w_cout;
            r_ovf       <= ovf_flag(r_a[W], ~r_bn[W], w_sum[SLICE-1]);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign D         = r_d;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_sub48_seq.sv
// Self-checking bench for sub48_seq: directed vector table, stall/reset sequences, random stream.
module tb_sub48_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] A;
  logic [47:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] D;
  logic        bout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [47:0] a;
    logic [47:0] b;
    logic [47:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t vecs[8];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  sub48_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  function automatic vec_t model(input logic [47:0] a, input logic [47:0] b);
    vec_t        v;
    logic [48:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    v.a  = a;
    v.b  = b;
    v.d  = diff[47:0];
    v.bo = diff[48];
    v.ov = (a[47] != b[47]) && (diff[47] != a[47]);
    return v;
  endfunction

  task automatic run_op(input logic [47:0] a, input logic [47:0] b, input logic [47:0] d_e,
                        input logic bo_e, input logic ov_e, input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk({nm, "_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; A = a; B = b;
    step();
    in_valid = 1'b0; A = rnd48(); B = rnd48();
    chk({nm, "_busy"}, 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk({nm, "_latency"}, 64'(n), 64'd3);
    chk({nm, "_D"}, 64'(D), 64'(d_e));
    chk({nm, "_flags"}, 64'({bout, ovf}), 64'({bo_e, ov_e}));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, "_release"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    vecs[0] = '{48'h0000_0000_0005, 48'h0000_0000_0003, 48'h0000_0000_0002, 1'b0, 1'b0};
    vecs[1] = '{48'h0000_0000_0000, 48'h0000_0000_0001, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{48'h8000_0000_0000, 48'h0000_0000_0001, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1};
    vecs[3] = '{48'h7FFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'h8000_0000_0000, 1'b1, 1'b1};
    vecs[4] = '{48'h0000_0001_0000, 48'h0000_0000_0001, 48'h0000_0000_FFFF, 1'b0, 1'b0};
    vecs[5] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 48'h0000_0000_0000, 1'b0, 1'b0};
    vecs[6] = '{48'h0000_0000_000A, 48'h0000_0000_000A, 48'h0000_0000_0000, 1'b0, 1'b0};
    vecs[7] = '{48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 48'h0246_8ACF_1357, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_state", 64'({in_ready, out_valid, bout, ovf, D}), {12'h0, 4'b1000, 48'h0});

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].ov, $sformatf("vec%0d", i));
    end

    // Result held under back-pressure; new operands offered meanwhile must be ignored.
    in_valid = 1'b1; A = 48'h0001_0000_0000; B = 48'h0000_0001_0000;
    step();
    A = 48'h0000_0000_0007; B = 48'h0000_0000_0009;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      chk("stall_latency", 64'(n), 64'd3);
    end
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("stall_hold%0d", c), 64'({out_valid, in_ready, bout, ovf, D}),
          {12'h0, 4'b1000, 48'h0000_FFFF_0000});
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stall_reaccept", 64'({out_valid, in_ready}), 64'b01);
    run_op(48'h0000_0000_0003, 48'h0000_0000_0005, 48'hFFFF_FFFF_FFFE, 1'b1, 1'b0, "after_stall");

    // Reset sampled on the second slice edge abandons the operation.
    in_valid = 1'b1; A = 48'h0000_0000_0005; B = 48'h0000_0000_0003;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_state", 64'({out_valid, in_ready, D}), {14'h0, 2'b01, 48'h0});
    step(); step(); step(); step();
    chk("midrst_no_result", 64'({out_valid, in_ready}), 64'b01);
    run_op(48'd10, 48'd10, 48'd0, 1'b0, 1'b0, "post_rst");

    // Random stream with stalls on both handshakes.
    begin
      int ops_in, ops_out, cyc;
      vec_t e;
      ops_in = 0; ops_out = 0; cyc = 0;
      while (ops_out < 1000 && cyc < 40000) begin
        in_valid  = (ops_in < 1000) && ($urandom_range(0, 3) != 0);
        A         = rnd48();
        B         = rnd48();
        out_ready = ($urandom_range(0, 2) != 0);
        if (in_valid && in_ready) begin
          exp_q.push_back(model(A, B));
          ops_in++;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("rand_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("rand%0d", ops_out), 64'({bout, ovf, D}), {14'h0, e.bo, e.ov, e.d});
          end
          ops_out++;
        end
        step();
        cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("rand_count", 64'(ops_out), 64'd1000);
      chk("rand_leftover", 64'(exp_q.size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
